// File: rtl/region_select_ctrl.sv
// region_select_ctrl: frame-rate glove-region qualifier/holder driving the overlay highlight.
// Optional macro ROUND_ROBIN_EN selects round-robin arbitration instead of fixed red>green>blue>yellow.
`default_nettype none

module region_select_ctrl #(
  parameter int HOLD_FRAMES = 3,
  parameter int SHOW_FRAMES = 30,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       en_regions,
  input  logic       red_flag,
  input  logic       green_flag,
  input  logic       blue_flag,
  input  logic       yellow_flag,
  output logic [3:0] region_onehot,
  output logic [1:0] region_id,
  output logic       region_valid,
  output logic       hit_pulse,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_SHOW    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] C_SHOW = CNT_W'(SHOW_FRAMES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  state_t           r_state;
  logic [1:0]       r_cand;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_scnt;
`ifdef ROUND_ROBIN_EN
  logic [1:0]       r_rr_ptr;
`endif

  logic [3:0]       w_flags;
  logic             w_sample;
  logic             w_any;
  logic             w_cand_hit;
  logic [1:0]       w_winner;
  logic [CNT_W-1:0] w_hcnt_inc;
  logic [CNT_W-1:0] w_scnt_inc;
  logic             w_enter_show;
  logic [1:0]       w_show_id;

  assign w_flags    = {yellow_flag, blue_flag, green_flag, red_flag};
  assign w_sample   = frame_start & en_regions;
  assign w_any      = |w_flags;
  assign w_cand_hit = w_flags[r_cand];
  assign w_hcnt_inc = (r_hcnt == C_MAX) ? r_hcnt : r_hcnt + C_ONE;
  assign w_scnt_inc = (r_scnt == C_MAX) ? r_scnt : r_scnt + C_ONE;

  // Descending scan so the highest-priority asserted flag is assigned last.
  always_comb begin
    w_winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
`ifdef ROUND_ROBIN_EN
      if (w_flags[r_rr_ptr + 2'(k)]) w_winner = r_rr_ptr + 2'(k);
`else
      if (w_flags[k]) w_winner = 2'(k);
`endif
    end
  end

  assign w_enter_show = w_sample &&
      (((r_state == S_IDLE) && w_any && (C_HOLD <= C_ONE)) ||
       ((r_state == S_QUALIFY) && w_cand_hit && (w_hcnt_inc >= C_HOLD)));
  assign w_show_id = (r_state == S_IDLE) ? w_winner : r_cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cand        <= 2'd0;
      r_hcnt        <= '0;
      r_scnt        <= '0;
      region_onehot <= 4'd0;
      region_id     <= 2'd0;
      region_valid  <= 1'b0;
      hit_pulse     <= 1'b0;
      busy          <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_rr_ptr      <= 2'd0;
`endif
    end else if (!en_regions) begin
      r_state       <= S_IDLE;
      r_cand        <= 2'd0;
      r_hcnt        <= '0;
      r_scnt        <= '0;
      region_onehot <= 4'd0;
      region_id     <= 2'd0;
      region_valid  <= 1'b0;
      hit_pulse     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sample && w_any) begin
            r_cand  <= w_winner;
            r_hcnt  <= C_ONE;
            r_state <= S_QUALIFY;
            busy    <= 1'b1;
          end
        end
        S_QUALIFY: begin
          if (w_sample) begin
            if (w_cand_hit) begin
              r_hcnt <= w_hcnt_inc;
            end else if (w_any) begin
              r_cand <= w_winner;
              r_hcnt <= C_ONE;
            end else begin
              r_hcnt  <= '0;
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        S_SHOW: begin
          if (w_sample) begin
            r_scnt <= w_scnt_inc;
            if (w_scnt_inc >= C_SHOW) begin
              r_state       <= S_RELEASE;
              region_valid  <= 1'b0;
              region_onehot <= 4'd0;
            end
          end
        end
        S_RELEASE: begin
          // Wait for the confirmed glove to leave so it cannot re-trigger.
          if (w_sample && !w_cand_hit) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_show) begin
        r_state       <= S_SHOW;
        r_cand        <= w_show_id;
        r_hcnt        <= '0;
        r_scnt        <= '0;
        hit_pulse     <= 1'b1;
        region_valid  <= 1'b1;
        region_onehot <= 4'b0001 << w_show_id;
        region_id     <= w_show_id;
        busy          <= 1'b1;
`ifdef ROUND_ROBIN_EN
        r_rr_ptr      <= w_show_id + 2'd1;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_region_select_ctrl.sv
// tb_region_select_ctrl: directed self-checking bench for region_select_ctrl (HOLD=3, SHOW=4).
`default_nettype none

module tb_region_select_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       en_regions;
  logic       red_flag, green_flag, blue_flag, yellow_flag;
  logic [3:0] region_onehot;
  logic [1:0] region_id;
  logic       region_valid;
  logic       hit_pulse;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int hit_cnt = 0;
  int hit_base;

  region_select_ctrl #(
    .HOLD_FRAMES(3),
    .SHOW_FRAMES(4),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .en_regions(en_regions),
    .red_flag(red_flag),
    .green_flag(green_flag),
    .blue_flag(blue_flag),
    .yellow_flag(yellow_flag),
    .region_onehot(region_onehot),
    .region_id(region_id),
    .region_valid(region_valid),
    .hit_pulse(hit_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hit_pulse) hit_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One frame_start cycle with flags {yellow,blue,green,red}; returns at the next negedge.
  task automatic sample(input logic [3:0] f);
    @(negedge clk);
    frame_start = 1'b1;
    {yellow_flag, blue_flag, green_flag, red_flag} = f;
    @(negedge clk);
    frame_start = 1'b0;
    {yellow_flag, blue_flag, green_flag, red_flag} = 4'd0;
  endtask

  task automatic sample_n(input logic [3:0] f, input int n);
    for (int i = 0; i < n; i++) sample(f);
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    en_regions = 1'b1;
    {yellow_flag, blue_flag, green_flag, red_flag} = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_onehot", 32'(region_onehot), 32'h0);
    check_val("rst_id", 32'(region_id), 32'h0);
    check_val("rst_valid", 32'(region_valid), 32'h0);
    check_val("rst_hit", 32'(hit_pulse), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Green confirmed after 3 samples, shown for 4 samples
    sample(4'b0010);
    check_val("g1_busy", 32'(busy), 32'h1);
    check_val("g1_valid", 32'(region_valid), 32'h0);
    sample(4'b0010);
    check_val("g2_hit", 32'(hit_pulse), 32'h0);
    sample(4'b0010);
    check_val("g3_hit", 32'(hit_pulse), 32'h1);
    check_val("g3_valid", 32'(region_valid), 32'h1);
    check_val("g3_onehot", 32'(region_onehot), 32'h2);
    check_val("g3_id", 32'(region_id), 32'h1);
    @(negedge clk);
    check_val("g_hit_1cyc", 32'(hit_pulse), 32'h0);
    check_val("g_valid_hold", 32'(region_valid), 32'h1);
    sample_n(4'b0010, 3);
    check_val("g_show3_valid", 32'(region_valid), 32'h1);
    sample(4'b0010);
    check_val("g_show4_valid", 32'(region_valid), 32'h0);
    check_val("g_show4_onehot", 32'(region_onehot), 32'h0);
    check_val("g_release_busy", 32'(busy), 32'h1);
    sample(4'b0000);
    check_val("g_idle_busy", 32'(busy), 32'h0);

    // Red+blue simultaneously
    sample_n(4'b0101, 3);
`ifdef ROUND_ROBIN_EN
    check_val("rb_onehot", 32'(region_onehot), 32'h4);
    check_val("rb_id", 32'(region_id), 32'h2);
`else
    check_val("rb_onehot", 32'(region_onehot), 32'h1);
    check_val("rb_id", 32'(region_id), 32'h0);
`endif
    sample_n(4'b0000, 4);
    sample(4'b0000);
    check_val("rb_idle_busy", 32'(busy), 32'h0);

    // Blue twice then nothing: abandon qualification
    hit_base = hit_cnt;
    sample_n(4'b0100, 2);
    check_val("b2_busy", 32'(busy), 32'h1);
    sample(4'b0000);
    check_val("b_abort_busy", 32'(busy), 32'h0);
    check_val("b_abort_valid", 32'(region_valid), 32'h0);
    check_val("b_abort_hits", 32'(hit_cnt - hit_base), 32'h0);

    // Yellow held for 20 samples: one hit, then RELEASE until it drops
    hit_base = hit_cnt;
    sample_n(4'b1000, 20);
    check_val("y20_hits", 32'(hit_cnt - hit_base), 32'h1);
    check_val("y20_busy", 32'(busy), 32'h1);
    check_val("y20_valid", 32'(region_valid), 32'h0);
    sample(4'b0000);
    check_val("y_drop_busy", 32'(busy), 32'h0);
    sample_n(4'b1000, 3);
    check_val("y_again_hit", 32'(hit_pulse), 32'h1);
    check_val("y_again_onehot", 32'(region_onehot), 32'h8);
    check_val("y_again_id", 32'(region_id), 32'h3);

    // en_regions dropped during SHOW
    @(negedge clk);
    en_regions = 1'b0;
    @(negedge clk);
    check_val("en_valid", 32'(region_valid), 32'h0);
    check_val("en_onehot", 32'(region_onehot), 32'h0);
    check_val("en_id", 32'(region_id), 32'h0);
    check_val("en_busy", 32'(busy), 32'h0);

    // frame_start ignored while disabled
    sample_n(4'b0010, 3);
    check_val("dis_busy", 32'(busy), 32'h0);
    check_val("dis_valid", 32'(region_valid), 32'h0);
    en_regions = 1'b1;

    // Candidate switch restarts the count
    sample_n(4'b0001, 2);
    sample_n(4'b0010, 2);
    check_val("sw_valid_early", 32'(region_valid), 32'h0);
    check_val("sw_busy", 32'(busy), 32'h1);
    sample(4'b0010);
    check_val("sw_valid", 32'(region_valid), 32'h1);
    check_val("sw_onehot", 32'(region_onehot), 32'h2);
    @(negedge clk);
    en_regions = 1'b0;
    @(negedge clk);
    en_regions = 1'b1;

    // Reset mid-QUALIFY
    sample_n(4'b0010, 2);
    check_val("rq_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check_val("rq_busy_async", 32'(busy), 32'h0);
    check_val("rq_valid_async", 32'(region_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sample_n(4'b0010, 2);
    check_val("rq_no_hit_2", 32'(region_valid), 32'h0);
    sample(4'b0010);
    check_val("rq_hit_3", 32'(hit_pulse), 32'h1);
    check_val("rq_onehot_3", 32'(region_onehot), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
